sdram_fb_arbiter: RTL

SDRAM_FB_ARBITER -- requirements
Module: sdram_fb_arbiter

---
 rtl/sdram_pkg.sv | 17 +
 rtl/sdram_fb_arbiter_if.sv | 12 +
 rtl/sync_fifo.sv | 42 ++++
 rtl/sdram_fb_arbiter.sv | 112 +++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: controller command encoding, arbiter FSM states and bus widths shared by the framebuffer path.
package sdram_pkg;
  localparam int ADDR_W = 22;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {
    CMD_NOP          = 2'd0,
    CMD_WRITE        = 2'd1,
    CMD_READ         = 2'd2,
    CMD_SELF_REFRESH = 2'd3
  } sdram_cmd_t;
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_READ_WAIT  = 2'd1,
    ST_WRITE_WAIT = 2'd2,
    ST_GAP        = 2'd3
  } fb_state_t;
endpackage

// File: rtl/sdram_fb_arbiter_if.sv
// sdram_fb_arbiter_if: command/data bus between the framebuffer arbiter (master) and the SDRAM controller (slave).
interface sdram_fb_arbiter_if;
  import sdram_pkg::*;
  sdram_cmd_t        command;
  logic [ADDR_W-1:0] data_address;
  logic [DATA_W-1:0] data_write;
  logic [DATA_W-1:0] data_read;
  logic              data_read_valid;
  logic              data_write_done;
  modport master (output command, data_address, data_write, input data_read, data_read_valid, data_write_done);
  modport slave  (input command, data_address, data_write, output data_read, data_read_valid, data_write_done);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with occupancy output; clr_i empties it in one cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [AW:0]      level_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] lvl_q;
  logic do_push, do_pop;
  assign do_pop  = pop_i && lvl_q != '0;
  assign do_push = push_i && !clr_i && (lvl_q != (AW+1)'(DEPTH) || do_pop);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else if (clr_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else begin
      wp_q  <= wp_q + AW'(do_push);
      rp_q  <= rp_q + AW'(do_pop);
      lvl_q <= lvl_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wp_q] <= data_i;
  assign valid_o = lvl_q != '0;
  assign data_o  = valid_o ? mem_q[rp_q] : '0;
  assign level_o = lvl_q;
endmodule

// File: rtl/sdram_fb_arbiter.sv
// sdram_fb_arbiter: shares one SDRAM controller port between a pixel writer and scanout prefetch.
// Reads win while the prefetch FIFO is below LOW_WATER; exactly one controller transaction in flight.
module sdram_fb_arbiter
  import sdram_pkg::*;
#(
  parameter int                FIFO_DEPTH  = 16,
  parameter int                LOW_WATER   = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 22'h0,
  parameter int                FRAME_WORDS = 130560
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              frame_start,
  input  logic              pop,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              underflow,
  sdram_fb_arbiter_if.master mem
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BASE_ADDR + FRAME_WORDS - 1);
  fb_state_t state_q, state_d;
  sdram_cmd_t cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d, rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic discard_q, discard_d, underflow_q;
  logic [1:0] sync_q;
  logic [LW-1:0] level;
  logic run, idle, rd_ok, rd_go, rd_done, push;
  // sync_q delays the first command until two edges after reset release
  assign run      = sync_q[1];
  assign idle     = run && state_q == ST_IDLE;
  assign rd_ok    = idle && int'(level) + 1 <= FIFO_DEPTH;
  assign rd_go    = rd_ok && (int'(level) < LOW_WATER || !wr_valid);
  assign wr_ready = idle && !rd_go;
  assign rd_done  = state_q == ST_READ_WAIT && mem.data_read_valid;
  assign push     = rd_done && !discard_q && !frame_start;
  assign rd_addr_d = frame_start ? BASE_ADDR
                   : push ? (rd_addr_q == LAST_ADDR ? BASE_ADDR : rd_addr_q + 22'd1)
                   : rd_addr_q;
  assign discard_d = (state_q == ST_READ_WAIT && frame_start && !mem.data_read_valid) ? 1'b1
                   : rd_done ? 1'b0 : discard_q;
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_go) begin
          state_d = ST_READ_WAIT;
          cmd_d   = CMD_READ;
          addr_d  = frame_start ? BASE_ADDR : rd_addr_q;
        end else if (wr_valid && wr_ready) begin
          state_d = ST_WRITE_WAIT;
          cmd_d   = CMD_WRITE;
          addr_d  = wr_addr;
          wdat_d  = wr_data;
        end
      end
      ST_READ_WAIT: begin
        state_d = mem.data_read_valid ? ST_GAP : state_q;
        cmd_d   = mem.data_read_valid ? CMD_NOP : cmd_q;
      end
      ST_WRITE_WAIT: begin
        state_d = mem.data_write_done ? ST_GAP : state_q;
        cmd_d   = mem.data_write_done ? CMD_NOP : cmd_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      state_q     <= ST_IDLE;
      cmd_q       <= CMD_NOP;
      addr_q      <= '0;
      wdat_q      <= '0;
      rd_addr_q   <= BASE_ADDR;
      discard_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], 1'b1};
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      wdat_q      <= wdat_d;
      rd_addr_q   <= rd_addr_d;
      discard_q   <= discard_d;
      underflow_q <= pop && !pix_valid;
    end
  end
  sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (frame_start),
    .push_i  (push),
    .data_i  (mem.data_read),
    .pop_i   (pop),
    .data_o  (pix_data),
    .valid_o (pix_valid),
    .level_o (level)
  );
  assign mem.command      = cmd_q;
  assign mem.data_address = addr_q;
  assign mem.data_write   = wdat_q;
  assign underflow        = underflow_q;
endmodule
